snes_multi_poller: RTL
======================

// Module: snes_multi_poller
// PURPOSE
//  Next-generation SNES/NES pad poller: periodically latches and serially reads N pads on shared con_clock/con_latch.
//  Per-pad serial data lines; configurable bit count, poll rate and bit timing.
//  Presents active-high button state (1 = pressed), one-cycle press/release event masks and a frame-valid strobe.
//  Sits in IOSS between pad pins and the CPU-visible input registers.
// PARAMETERS
//  NUM_PADS     2       pads read in parallel (1..4)
//  NUM_BITS     16      bits per frame (8 = NES, 16 = SNES; 2..32)
//  POLL_PERIOD  833333  clock cycles between automatic polls (60 Hz @ 50 MHz)
//  HALF_BIT     300     clock cycles per con_clock level
// PORTS
//  clock        in   1                  system clock
//  reset        in   1                  asynchronous, active-high reset
//  poll_en      in   1                  1 = automatic polling enabled
//  poll_req     in   1                  single-cycle software poll request
//  con_serial   in   NUM_PADS           pad data, active-low (0 = pressed)
//  con_clock    out  1                  shared pad clock, idles high
//  con_latch    out  1                  shared pad latch, active-high
//  busy         out  1                  1 while a frame is in progress
//  con_state    out  NUM_PADS*NUM_BITS  pad i at [i*NUM_BITS +: NUM_BITS]; 1 = pressed
//  con_pressed  out  NUM_PADS*NUM_BITS  bits that went 0->1 this frame; valid with frame_valid only
//  con_released out  NUM_PADS*NUM_BITS  bits that went 1->0 this frame; valid with frame_valid only
//  frame_valid  out  1                  one-cycle strobe coinciding with con_state update
//  overrun      out  1                  sticky: poll trigger arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state IDLE; con_clock=1, con_latch=0, busy=0.
//   con_state/con_pressed/con_released=0; frame_valid=0, overrun=0; period/bit counters=0.
//   A partial frame is discarded, never committed.
//  Bit clock: phase counter 0..HALF_BIT-1 runs free. At terminal count div_clk toggles and issues a one-cycle strobe:
//   rise (0->1) or fall (1->0).
//  Poll timer: free-running 0..POLL_PERIOD-1; terminal count = tick. Counts regardless of poll_en.
//  Trigger = (tick & poll_en) | poll_req. Trigger in IDLE -> ALIGN next cycle.
//   Trigger while busy: ignored (no queueing), overrun<=1.
//  FSM IDLE -> ALIGN -> LATCH -> SHIFT -> IDLE:
//   IDLE   outputs idle; busy=0.
//   ALIGN  busy=1; wait for rise -> LATCH.
//   LATCH  con_latch=1 for exactly one div period (2*HALF_BIT cycles); next rise -> SHIFT.
//   SHIFT  con_clock=div_clk; on each fall sample all con_serial into per-pad shift regs.
//          The first-received bit ends at bit 0.
//          Bit counter ($clog2(NUM_BITS+1) wide) increments on each rise.
//          On the rise making count==NUM_BITS: commit, go to IDLE, con_clock returns high.
//  Commit cycle (registered, visible the cycle after the final rise):
//   new = ~shift. con_pressed = new & ~con_state_old; con_released = ~new & con_state_old.
//   con_state <= new; frame_valid=1 for one cycle.
//   con_pressed/con_released are 0 in every other cycle.
//  Frame latency: trigger -> frame_valid <= (2*HALF_BIT)*(NUM_BITS+2) + 2 cycles.
//  Simultaneous tick & poll_req in IDLE: one frame, no overrun.
//  poll_en deasserted mid-frame: the frame completes.
//  Disconnected pad (line pulled high) reads all-0 state; no special handling.
//  Outputs are registered except con_clock/con_latch (decoded from state and div_clk).
// STRUCTURE
//  snes_pkg: poll state enum, button index constants.
//   SNES: B=0 Y=1 SEL=2 START=3 UP=4 DN=5 LT=6 RT=7 A=8 X=9 L=10 R=11.
//   NES: A=0 B=1 SEL=2 START=3 UP..RT=4..7.
//  Sub-module snes_bit_clock #(HALF_BIT): outputs div_clk, rise, fall; one instance.
//  Per-pad shift registers come from a generate loop, not separate modules.
// TESTING (pad BFM shifts on con_clock rise, reloads on latch; NUM_PADS=2, NUM_BITS=16, HALF_BIT=4, POLL_PERIOD=2000)
//  Pad0 holds B+START (0x0009), pad1 holds R (0x0800); poll_en=1 ->
//   frame_valid once; con_state=0x0800_0009; con_pressed=0x0800_0009.
//  Second frame with pad0 releasing B only -> con_released[15:0]=0x0001, con_pressed=0, con_state[15:0]=0x0008.
//  poll_en=0, poll_req pulse ->
//   exactly 1 latch pulse of 8 cycles, 16 con_clock lows of 4 cycles each, frame_valid within 146 cycles.
//  poll_req pulsed while busy -> overrun=1, no extra latch pulse; overrun stays 1 until reset.
//  reset asserted mid-SHIFT (bit 7) -> con_clock=1, con_latch=0, busy=0 immediately; con_state=0; no frame_valid.
//  NUM_BITS=8 NES build with pad0 = A+RIGHT -> con_state[7:0]=0x81 after 8 clock pulses.

Source files
------------

// File: rtl/snes_pkg.sv
// Shared types and button bit positions for the SNES/NES pad poller.
`timescale 1ns/1ps
package snes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_LATCH,
        ST_SHIFT
    } poll_state_t;

    // SNES frame bit positions (bit 0 is the first bit clocked out of the pad)
    localparam int SNES_B     = 0;
    localparam int SNES_Y     = 1;
    localparam int SNES_SEL   = 2;
    localparam int SNES_START = 3;
    localparam int SNES_UP    = 4;
    localparam int SNES_DN    = 5;
    localparam int SNES_LT    = 6;
    localparam int SNES_RT    = 7;
    localparam int SNES_A     = 8;
    localparam int SNES_X     = 9;
    localparam int SNES_L     = 10;
    localparam int SNES_R     = 11;

    // NES frame bit positions
    localparam int NES_A      = 0;
    localparam int NES_B      = 1;
    localparam int NES_SEL    = 2;
    localparam int NES_START  = 3;
    localparam int NES_UP     = 4;
    localparam int NES_DN     = 5;
    localparam int NES_LT     = 6;
    localparam int NES_RT     = 7;

endpackage

// File: rtl/snes_multi_poller_if.sv
// Pad pins plus host-facing control and button-state bus of the poller.
`timescale 1ns/1ps
interface snes_multi_poller_if #(
    parameter int NUM_PADS = 2,
    parameter int NUM_BITS = 16
);
    logic                         poll_en;
    logic                         poll_req;
    logic [NUM_PADS-1:0]          con_serial;
    logic                         con_clock;
    logic                         con_latch;
    logic                         busy;
    logic [NUM_PADS*NUM_BITS-1:0] con_state;
    logic [NUM_PADS*NUM_BITS-1:0] con_pressed;
    logic [NUM_PADS*NUM_BITS-1:0] con_released;
    logic                         frame_valid;
    logic                         overrun;

    // master: the poller itself; slave: host logic and pad pins
    modport master (
        input  poll_en, poll_req, con_serial,
        output con_clock, con_latch, busy, con_state, con_pressed,
               con_released, frame_valid, overrun
    );

    modport slave (
        output poll_en, poll_req, con_serial,
        input  con_clock, con_latch, busy, con_state, con_pressed,
               con_released, frame_valid, overrun
    );
endinterface

// File: rtl/snes_bit_clock.sv
// Free-running pad bit clock divider: div_clk toggles every HALF_BIT cycles.
`timescale 1ns/1ps
module snes_bit_clock #(
    parameter int HALF_BIT = 300
) (
    input  logic clock,
    input  logic reset,
    output logic div_clk,
    output logic rise,
    output logic fall
);
    localparam int PW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;

    logic [PW-1:0] phase;
    logic          tc;

    assign tc   = (phase == PW'(HALF_BIT - 1));
    // strobes coincide with the edge on which div_clk changes level
    assign rise = tc & ~div_clk;
    assign fall = tc & div_clk;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase   <= '0;
            div_clk <= 1'b1;
        end else if (tc) begin
            phase   <= '0;
            div_clk <= ~div_clk;
        end else begin
            phase   <= phase + 1'b1;
        end
    end
endmodule

// File: rtl/snes_multi_poller.sv
// Periodic latch-and-shift reader for NUM_PADS SNES/NES pads on a shared clock/latch.
//  state  | meaning
//  IDLE   | no frame; con_clock high, con_latch low
//  ALIGN  | frame requested, waiting for a bit-clock rise
//  LATCH  | con_latch high for one full bit period
//  SHIFT  | con_clock follows div_clk; sample on fall, count on rise
`timescale 1ns/1ps
module snes_multi_poller
    import snes_pkg::*;
#(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 16,
    parameter int POLL_PERIOD = 833333,
    parameter int HALF_BIT    = 300
) (
    input  logic                 clock,
    input  logic                 reset,
    snes_multi_poller_if.master  bus
);
    localparam int W  = NUM_PADS * NUM_BITS;
    localparam int CW = $clog2(NUM_BITS + 1);
    localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    poll_state_t   state, state_nx;
    logic          div_clk, rise, fall;
    logic [TW-1:0] poll_cnt;
    logic          tick, trigger, commit;
    logic [CW-1:0] bit_cnt;
    logic [W-1:0]  shift_all, new_state;
    logic [W-1:0]  state_q, pressed_q, released_q;
    logic          busy_q, frame_valid_q, overrun_q;

    snes_bit_clock #(.HALF_BIT(HALF_BIT)) u_bit_clock (
        .clock   (clock),
        .reset   (reset),
        .div_clk (div_clk),
        .rise    (rise),
        .fall    (fall)
    );

    assign tick    = (poll_cnt == TW'(POLL_PERIOD - 1));
    assign trigger = (tick & bus.poll_en) | bus.poll_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     poll_cnt <= '0;
        else if (tick) poll_cnt <= '0;
        else           poll_cnt <= poll_cnt + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        case (state)
            ST_IDLE:  if (trigger) state_nx = ST_ALIGN;
            ST_ALIGN: if (rise)    state_nx = ST_LATCH;
            ST_LATCH: if (rise)    state_nx = ST_SHIFT;
            ST_SHIFT: begin
                if (rise && bit_cnt == CW'(NUM_BITS - 1)) begin
                    state_nx = ST_IDLE;
                    commit   = 1'b1;
                end
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  bit_cnt <= '0;
        else if (state != ST_SHIFT) bit_cnt <= '0;
        else if (rise)              bit_cnt <= bit_cnt + 1'b1;
    end

    // First bit out of the pad ends up at bit 0
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [NUM_BITS-1:0] sr;
        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                sr <= '0;
            else if (state == ST_SHIFT && fall)
                sr <= {bus.con_serial[p], sr[NUM_BITS-1:1]};
        end
        assign shift_all[p*NUM_BITS +: NUM_BITS] = sr;
    end

    assign new_state = ~shift_all;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= '0;
            pressed_q     <= '0;
            released_q    <= '0;
            busy_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            busy_q        <= (state_nx != ST_IDLE);
            frame_valid_q <= commit;
            pressed_q     <= commit ? (new_state & ~state_q) : '0;
            released_q    <= commit ? (~new_state & state_q) : '0;
            if (commit)
                state_q <= new_state;
            if (trigger && state != ST_IDLE)
                overrun_q <= 1'b1;
        end
    end

    assign bus.con_clock    = (state == ST_SHIFT) ? div_clk : 1'b1;
    assign bus.con_latch    = (state == ST_LATCH);
    assign bus.busy         = busy_q;
    assign bus.con_state    = state_q;
    assign bus.con_pressed  = pressed_q;
    assign bus.con_released = released_q;
    assign bus.frame_valid  = frame_valid_q;
    assign bus.overrun      = overrun_q;
endmodule
